branch_predict_bht: RTL and testbench
=====================================

# branch_predict_bht

Parametrised successor to the combinational branch decision logic: resolves conditional branches and jumps in EX from the ALU result, and adds a direct-mapped branch history table (BHT) of 2-bit saturating counters. The BHT predicts branch direction for the fetch stage and is trained in EX. The block sits between IF (prediction lookup) and EX (resolution), and raises a registered mispredict/redirect to the PC logic and pipeline flush control.

## Interface
Parameters:
- XLEN, 32, datapath/PC width
- BHT_ENTRIES, 64, counter count; power of two, 2..1024
- CNT_W, 32, width of the performance counters

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- if_pc  in  XLEN  fetch PC for lookup
- if_pred_taken  out  1  predicted direction (combinational)
- ex_valid  in  1  EX holds a real instruction
- ex_stall  in  1  EX stalled; blocks update and flush
- ex_is_branch  in  1  conditional branch in EX
- ex_pc  in  XLEN  PC of EX instruction
- alu_result  in  XLEN  ALU compare/subtract result
- cmp_opcode  in  3  ALU_CMP_* code
- pc_jump  in  1  unconditional jump (JAL/JALR) in EX
- ex_pred_taken  in  1  prediction carried down the pipe with the instruction
- branch  out  2  EX decision: 00 none, 01 taken branch, 10 jump (combinational)
- flush  out  1  registered mispredict pulse
- redirect_taken  out  1  registered: 1 = go to target, 0 = go to ex_pc+4
- branch_count  out  CNT_W  resolved conditional branches
- mispredict_count  out  CNT_W  mispredicted conditional branches

## Operation
- Index: idx = pc[IDX_W+1:2], where IDX_W = log2(BHT_ENTRIES).
- Counter states: 00 strong NT, 01 weak NT, 10 weak T, 11 strong T. Prediction = counter[1].
- Condition `taken`, by cmp_opcode:
  - EQ: alu_result == 0
  - NE: alu_result != 0
  - LT / LTU: alu_result[0]
  - GE / GEU: !alu_result[0]
  - undefined codes: 0
- branch output:
  - 10 if pc_jump (pc_jump overrides everything)
  - else 01 if ex_is_branch & taken
  - else 00
  - Forced to 00 when !ex_valid.
- Update event: upd = ex_valid & !ex_stall & ex_is_branch & !pc_jump.
  - On upd, counter[idx(ex_pc)] increments if taken, decrements otherwise, saturating at 11 and 00.
- Mispredict: upd & (taken != ex_pred_taken). Jumps never mispredict here; they are redirected via branch.
- Perf counters:
  - branch_count increments on upd.
  - mispredict_count increments on mispredict.
  - Both saturate at all-ones.

## Timing
- Reset: all counters 01; flush 0; redirect_taken 0; both perf counters 0. if_pred_taken therefore reads 0 from reset.
- if_pred_taken and branch are combinational, with zero latency.
- Counter update is written at the clock edge where upd is true. It is visible to lookup from the following cycle.
- Same-cycle lookup of the index being written returns the old value (no bypass).
- flush and redirect_taken are registered, one cycle after the EX cycle.
  - flush stays high for exactly one cycle per mispredict.
  - redirect_taken is loaded with `taken` only on mispredict; otherwise it holds its value.
- Back-to-back mispredicts produce consecutive flush pulses.
- While ex_stall is high: no update, no flush, no count, whatever the inputs. branch still reflects the inputs.
- Asserting rst mid-operation clears the outputs and table immediately, with no clock needed. The first update after deassertion is taken normally.

## Structure
- Shared include branch_defs.v holds:
  - BR_NONE / BR_TAKEN / BR_JUMP (2-bit) encodings
  - counter state encodings and the reset value 01
- cmp_opcode codes come from the existing alu_opcode.v include.
- One sub-module is natural: bht_counter_array. It holds the counter storage with an async-read port and a sync saturating-update port, parameterised by entries.
- Condition evaluation, mispredict registers and perf counters live in the top module.

## Test plan
- Reset, then lookup at if_pc=0x100 -> if_pred_taken=0. Check flush=0 and both counts 0.
- ex_pc=0x100, EQ, alu_result=0, ex_pred_taken=0 -> branch=01, and flush=1 with redirect_taken=1 one cycle later. Next cycle, lookup at 0x100 -> if_pred_taken=1 (counter 10).
- Four taken updates at 0x200 then three not-taken -> counter goes 01→10→11→11→11→10→01→00, and prediction follows bit 1 each cycle.
- pc_jump=1 with EQ, alu_result=0, ex_is_branch=1 -> branch=10, no flush, counter at idx unchanged, branch_count unchanged.
- ex_stall=1 with a mispredicting GEU branch (alu_result[0]=1, ex_pred_taken=1) -> no flush, no count change. Deassert stall -> flush=1, redirect_taken=0.
- BHT_ENTRIES=4: ex_pc=0x0 and 0x10 alias to the same index -> update at one changes the lookup at the other. Assert rst between two updates -> counter back to 01.

Source files
------------

// File: rtl/branch_predict_bht_pkg.sv
// Shared encodings for branch resolution and the 2-bit direction counters.
// Also holds the ALU compare codes and the saturating counter step.
package branch_predict_bht_pkg;

  localparam logic [1:0] BR_NONE  = 2'b00;
  localparam logic [1:0] BR_TAKEN = 2'b01;
  localparam logic [1:0] BR_JUMP  = 2'b10;

  typedef enum logic [1:0] {
    CNT_SNT = 2'b00,
    CNT_WNT = 2'b01,
    CNT_WT  = 2'b10,
    CNT_ST  = 2'b11
  } bht_cnt_e;

  localparam logic [1:0] CNT_RESET = CNT_WNT;

  localparam logic [2:0] ALU_CMP_EQ  = 3'd0;
  localparam logic [2:0] ALU_CMP_NE  = 3'd1;
  localparam logic [2:0] ALU_CMP_LT  = 3'd4;
  localparam logic [2:0] ALU_CMP_GE  = 3'd5;
  localparam logic [2:0] ALU_CMP_LTU = 3'd6;
  localparam logic [2:0] ALU_CMP_GEU = 3'd7;

  function automatic logic [1:0] sat_update(input logic [1:0] cnt, input logic taken);
    logic [1:0] nxt;
    nxt = cnt;
    if (taken && cnt != CNT_ST) nxt = cnt + 2'd1;
    else if (!taken && cnt != CNT_SNT) nxt = cnt - 2'd1;
    return nxt;
  endfunction

endpackage

// File: rtl/branch_predict_bht_counter_array.sv
// Direct-mapped table of 2-bit counters: async read, one saturating update per clock.
// A write is seen by the read port only from the next cycle; no write-to-read bypass.
module bht_counter_array
  import branch_predict_bht_pkg::*;
#(
  parameter int ENTRIES = 64,
  parameter int IDX_W   = $clog2(ENTRIES)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [IDX_W-1:0] rd_idx_i,
  output logic [1:0]       rd_cnt_o,
  input  logic             upd_i,
  input  logic [IDX_W-1:0] upd_idx_i,
  input  logic             upd_taken_i
);

  logic [1:0] cnt_q [ENTRIES];
  logic [1:0] upd_cnt_d;

  assign rd_cnt_o  = cnt_q[rd_idx_i];
  assign upd_cnt_d = sat_update(cnt_q[upd_idx_i], upd_taken_i);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) cnt_q[i] <= CNT_RESET;
    end else if (upd_i) begin
      cnt_q[upd_idx_i] <= upd_cnt_d;
    end
  end

endmodule

// File: rtl/branch_predict_bht.sv
// EX branch resolution plus BHT direction prediction for IF; branch/prediction are combinational,
// flush/redirect are registered one cycle after EX; ex_stall blocks training, flush and counting.
module branch_predict_bht
  import branch_predict_bht_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter int BHT_ENTRIES = 64,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [XLEN-1:0]  if_pc,
  output logic             if_pred_taken,
  input  logic             ex_valid,
  input  logic             ex_stall,
  input  logic             ex_is_branch,
  input  logic [XLEN-1:0]  ex_pc,
  input  logic [XLEN-1:0]  alu_result,
  input  logic [2:0]       cmp_opcode,
  input  logic             pc_jump,
  input  logic             ex_pred_taken,
  output logic [1:0]       branch,
  output logic             flush,
  output logic             redirect_taken,
  output logic [CNT_W-1:0] branch_count,
  output logic [CNT_W-1:0] mispredict_count
);

  localparam int IDX_W = $clog2(BHT_ENTRIES);

  logic             taken;
  logic             upd;
  logic             mispredict;
  logic [1:0]       lookup_cnt;
  logic             flush_q;
  logic             redirect_q;
  logic [CNT_W-1:0] branch_count_q;
  logic [CNT_W-1:0] mispredict_count_q;
  logic             unused_pc_bits;

  always_comb begin
    taken = 1'b0;
    case (cmp_opcode)
      ALU_CMP_EQ:               taken = (alu_result == '0);
      ALU_CMP_NE:               taken = (alu_result != '0);
      ALU_CMP_LT, ALU_CMP_LTU:  taken = alu_result[0];
      ALU_CMP_GE, ALU_CMP_GEU:  taken = ~alu_result[0];
      default:                  taken = 1'b0;
    endcase
  end

  always_comb begin
    branch = BR_NONE;
    if (ex_valid) begin
      if (pc_jump) branch = BR_JUMP;
      else if (ex_is_branch && taken) branch = BR_TAKEN;
    end
  end

  // Jumps are resolved through 'branch' and never train the table.
  assign upd        = ex_valid & ~ex_stall & ex_is_branch & ~pc_jump;
  assign mispredict = upd & (taken != ex_pred_taken);

  bht_counter_array #(
    .ENTRIES (BHT_ENTRIES),
    .IDX_W   (IDX_W)
  ) u_bht (
    .clk         (clk),
    .rst         (rst),
    .rd_idx_i    (if_pc[IDX_W+1:2]),
    .rd_cnt_o    (lookup_cnt),
    .upd_i       (upd),
    .upd_idx_i   (ex_pc[IDX_W+1:2]),
    .upd_taken_i (taken)
  );

  assign if_pred_taken = lookup_cnt[1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flush_q            <= 1'b0;
      redirect_q         <= 1'b0;
      branch_count_q     <= '0;
      mispredict_count_q <= '0;
    end else begin
      flush_q <= mispredict;
      if (mispredict) redirect_q <= taken;
      if (upd && branch_count_q != {CNT_W{1'b1}})
        branch_count_q <= branch_count_q + 1'b1;
      if (mispredict && mispredict_count_q != {CNT_W{1'b1}})
        mispredict_count_q <= mispredict_count_q + 1'b1;
    end
  end

  assign flush            = flush_q;
  assign redirect_taken   = redirect_q;
  assign branch_count     = branch_count_q;
  assign mispredict_count = mispredict_count_q;

  assign unused_pc_bits = ^{if_pc[XLEN-1:IDX_W+2], if_pc[1:0], ex_pc[XLEN-1:IDX_W+2], ex_pc[1:0]};

endmodule

// File: tb/tb_branch_predict_bht.sv
// Bench for branch_predict_bht: a 64-entry/32-bit-count instance and a 4-entry/4-bit-count
// instance share stimulus and are compared against an array-based reference model.
module tb_branch_predict_bht;
  import branch_predict_bht_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] if_pc, ex_pc, alu_result;
  logic [2:0]  cmp_opcode;
  logic        ex_valid, ex_stall, ex_is_branch, pc_jump, ex_pred_taken;

  logic        pred64, pred4, fl64, fl4, rd64, rd4;
  logic [1:0]  br64, br4;
  logic [31:0] bc64, mc64;
  logic [3:0]  bc4, mc4;

  int n_chk = 0;
  int n_err = 0;

  // Reference state: counters as plain integers 0..3, counts as integers.
  int          tbl64 [64];
  int          tbl4 [4];
  bit          m_flush, m_redir;
  longint      m_bc64, m_mc64;
  int          m_bc4, m_mc4;

  always #5 clk = ~clk;

  branch_predict_bht #(.XLEN(32), .BHT_ENTRIES(64), .CNT_W(32)) dut (
    .clk(clk), .rst(rst), .if_pc(if_pc), .if_pred_taken(pred64),
    .ex_valid(ex_valid), .ex_stall(ex_stall), .ex_is_branch(ex_is_branch),
    .ex_pc(ex_pc), .alu_result(alu_result), .cmp_opcode(cmp_opcode),
    .pc_jump(pc_jump), .ex_pred_taken(ex_pred_taken), .branch(br64),
    .flush(fl64), .redirect_taken(rd64), .branch_count(bc64),
    .mispredict_count(mc64)
  );

  branch_predict_bht #(.XLEN(32), .BHT_ENTRIES(4), .CNT_W(4)) dut4 (
    .clk(clk), .rst(rst), .if_pc(if_pc), .if_pred_taken(pred4),
    .ex_valid(ex_valid), .ex_stall(ex_stall), .ex_is_branch(ex_is_branch),
    .ex_pc(ex_pc), .alu_result(alu_result), .cmp_opcode(cmp_opcode),
    .pc_jump(pc_jump), .ex_pred_taken(ex_pred_taken), .branch(br4),
    .flush(fl4), .redirect_taken(rd4), .branch_count(bc4),
    .mispredict_count(mc4)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic bit ref_taken(input logic [2:0] op, input logic [31:0] a);
    case (op)
      ALU_CMP_EQ:              return a == 32'd0;
      ALU_CMP_NE:              return a != 32'd0;
      ALU_CMP_LT, ALU_CMP_LTU: return a[0];
      ALU_CMP_GE, ALU_CMP_GEU: return !a[0];
      default:                 return 1'b0;
    endcase
  endfunction

  function automatic int ref_branch();
    if (!ex_valid) return 0;
    if (pc_jump) return 2;
    if (ex_is_branch && ref_taken(cmp_opcode, alu_result)) return 1;
    return 0;
  endfunction

  task automatic model_reset();
    foreach (tbl64[i]) tbl64[i] = 1;
    foreach (tbl4[i]) tbl4[i] = 1;
    m_flush = 0; m_redir = 0;
    m_bc64 = 0; m_mc64 = 0; m_bc4 = 0; m_mc4 = 0;
  endtask

  task automatic check_lookup(input string tag);
    chk({tag, ".pred64"}, {31'd0, pred64}, {31'd0, tbl64[(if_pc >> 2) % 64] >= 2});
    chk({tag, ".pred4"},  {31'd0, pred4},  {31'd0, tbl4[(if_pc >> 2) % 4] >= 2});
  endtask

  task automatic check_regs(input string tag);
    chk({tag, ".flush64"}, {31'd0, fl64}, {31'd0, m_flush});
    chk({tag, ".flush4"},  {31'd0, fl4},  {31'd0, m_flush});
    chk({tag, ".redir64"}, {31'd0, rd64}, {31'd0, m_redir});
    chk({tag, ".redir4"},  {31'd0, rd4},  {31'd0, m_redir});
    chk({tag, ".bcnt64"},  bc64, 32'(m_bc64));
    chk({tag, ".mcnt64"},  mc64, 32'(m_mc64));
    chk({tag, ".bcnt4"},   {28'd0, bc4}, 32'(m_bc4));
    chk({tag, ".mcnt4"},   {28'd0, mc4}, 32'(m_mc4));
  endtask

  task automatic drive(input bit v, input bit st, input bit isb, input bit jmp, input bit pt,
                       input logic [2:0] op, input logic [31:0] alu,
                       input logic [31:0] epc, input logic [31:0] ipc);
    ex_valid = v; ex_stall = st; ex_is_branch = isb; pc_jump = jmp;
    ex_pred_taken = pt; cmp_opcode = op; alu_result = alu; ex_pc = epc; if_pc = ipc;
  endtask

  // Checks combinational outputs before the edge, then registered state after it.
  task automatic cycle(input string tag);
    bit tk, upd, mp;
    int i64, i4;
    #2;
    chk({tag, ".br64"}, {30'd0, br64}, 32'(ref_branch()));
    chk({tag, ".br4"},  {30'd0, br4},  32'(ref_branch()));
    check_lookup({tag, ".pre"});
    tk  = ref_taken(cmp_opcode, alu_result);
    upd = ex_valid && !ex_stall && ex_is_branch && !pc_jump;
    mp  = upd && (tk != ex_pred_taken);
    @(posedge clk);
    #1;
    if (upd) begin
      i64 = (ex_pc >> 2) % 64;
      i4  = (ex_pc >> 2) % 4;
      tbl64[i64] = tk ? ((tbl64[i64] < 3) ? tbl64[i64] + 1 : 3) : ((tbl64[i64] > 0) ? tbl64[i64] - 1 : 0);
      tbl4[i4]   = tk ? ((tbl4[i4] < 3) ? tbl4[i4] + 1 : 3) : ((tbl4[i4] > 0) ? tbl4[i4] - 1 : 0);
      if (m_bc64 < 64'hFFFF_FFFF) m_bc64++;
      if (m_bc4 < 15) m_bc4++;
    end
    if (mp) begin
      if (m_mc64 < 64'hFFFF_FFFF) m_mc64++;
      if (m_mc4 < 15) m_mc4++;
      m_redir = tk;
    end
    m_flush = mp;
    check_regs(tag);
    check_lookup({tag, ".post"});
  endtask

  initial begin
    rst = 1'b1;
    drive(0, 0, 0, 0, 0, ALU_CMP_EQ, 32'd0, 32'h0, 32'h100);
    model_reset();
    #12;
    check_regs("reset");
    check_lookup("reset");
    @(posedge clk);
    #1;
    rst = 1'b0;

    drive(1, 0, 1, 0, 0, ALU_CMP_EQ, 32'd0, 32'h100, 32'h100);
    cycle("eq_mispredict");
    drive(0, 0, 0, 0, 0, ALU_CMP_EQ, 32'd0, 32'h100, 32'h100);
    cycle("idle_after_flush");

    for (int i = 0; i < 7; i++) begin
      drive(1, 0, 1, 0, 0, ALU_CMP_EQ, (i < 4) ? 32'd0 : 32'd1, 32'h200, 32'h200);
      cycle("train_0x200");
    end

    drive(1, 0, 1, 1, 0, ALU_CMP_EQ, 32'd0, 32'h300, 32'h300);
    cycle("jump");

    drive(1, 1, 1, 0, 1, ALU_CMP_GEU, 32'd1, 32'h400, 32'h400);
    cycle("stalled_geu");
    drive(1, 1, 1, 0, 1, ALU_CMP_GEU, 32'd1, 32'h400, 32'h400);
    cycle("stalled_geu2");
    drive(1, 0, 1, 0, 1, ALU_CMP_GEU, 32'd1, 32'h400, 32'h400);
    cycle("unstalled_geu");

    drive(1, 0, 1, 0, 0, ALU_CMP_EQ, 32'd0, 32'h0, 32'h10);
    cycle("alias_a");
    cycle("alias_b");

    drive(1, 0, 1, 0, 1, ALU_CMP_NE, 32'd5, 32'h10, 32'h0);
    cycle("pre_rst");
    rst = 1'b1;
    #2;
    model_reset();
    check_regs("mid_rst");
    check_lookup("mid_rst");
    #1;
    rst = 1'b0;
    drive(1, 0, 1, 0, 0, ALU_CMP_EQ, 32'd0, 32'h0, 32'h0);
    cycle("post_rst");

    for (int n = 0; n < 400; n++) begin
      logic [31:0] alu, epc, ipc;
      alu = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
      epc = {$urandom_range(0, 3) == 0 ? $urandom_range(0, 255) : 0, 8'd0} |
            32'($urandom_range(0, 63) << 2);
      ipc = ($urandom_range(0, 1) == 0) ? epc : 32'($urandom_range(0, 63) << 2);
      drive($urandom_range(0, 9) != 0, $urandom_range(0, 4) == 0,
            $urandom_range(0, 3) != 0, $urandom_range(0, 7) == 0,
            $urandom_range(0, 1) == 1, 3'($urandom_range(0, 7)), alu, epc, ipc);
      cycle("random");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
    $finish;
  end

endmodule
